// File: rtl/fdc_stim_nco.sv
// Square-wave NCO stimulus for the FDC. It generates a VCO-like output and a 50% reference gate.
// Optional auto-sweep of the FCW at window edges is enabled by defining FDC_NCO_SWEEP_EN.
module fdc_stim_nco #(
  parameter int unsigned ACC_W   = 16,
  parameter int unsigned FCW_W   = 8,
  parameter int unsigned REF_DIV = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [FCW_W-1:0] fcw_in,
  input  logic             fcw_valid,
  output logic             fcw_ready,
  input  logic             sweep_en,
  output logic             vco_out,
  output logic             ref_out,
  output logic             win_edge,
  output logic [FCW_W-1:0] fcw_cur
);

  localparam int unsigned CntW = (REF_DIV > 2) ? $clog2(REF_DIV) : 1;
  localparam logic [CntW-1:0] RefLast = CntW'(REF_DIV - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [CntW-1:0]  ref_cnt_q;
  logic             vco_q;
  logic             ref_q;
  logic             win_q;
  logic [FCW_W-1:0] fcw_cur_q;
  logic [FCW_W-1:0] fcw_cur_d;
  logic [FCW_W-1:0] pend_q;
  logic             pending_q;

  logic active;
  logic ref_wrap;
  logic win_hit;
  logic take;
  logic commit;

  assign active   = (state_q == StRun) && run;
  assign ref_wrap = (ref_cnt_q == RefLast);
  // The window edge is the wrap that drives ref_out from 0 to 1.
  assign win_hit  = active && ref_wrap && !ref_q;
  assign take     = fcw_valid && !pending_q;
  // In idle there is no window to protect, so a pending word is committed at once.
  assign commit   = pending_q && ((state_q == StIdle) || win_hit);

`ifdef FDC_NCO_SWEEP_EN
  always_comb begin
    fcw_cur_d = fcw_cur_q;
    if (commit) begin
      fcw_cur_d = pend_q;
    end else if (win_hit && sweep_en) begin
      // Zero is skipped so the sweep never parks the output at DC.
      fcw_cur_d = (fcw_cur_q == {FCW_W{1'b1}}) ? FCW_W'(1) : fcw_cur_q + FCW_W'(1);
    end
  end
`else
  logic unused_sweep_en;
  assign unused_sweep_en = sweep_en;

  always_comb begin
    fcw_cur_d = fcw_cur_q;
    if (commit) begin
      fcw_cur_d = pend_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      ref_cnt_q <= '0;
      vco_q     <= 1'b0;
      ref_q     <= 1'b0;
      win_q     <= 1'b0;
      fcw_cur_q <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
    end else begin
      fcw_cur_q <= fcw_cur_d;

      if (take) begin
        pend_q    <= fcw_in;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (run) state_q <= StRun;
        end
        StRun: begin
          if (!run) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (active) begin
        acc_q     <= acc_q + ACC_W'(fcw_cur_q);
        vco_q     <= acc_q[ACC_W-1];
        ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + CntW'(1);
        if (ref_wrap) ref_q <= ~ref_q;
        win_q     <= win_hit;
      end else begin
        acc_q     <= '0;
        vco_q     <= 1'b0;
        ref_cnt_q <= '0;
        ref_q     <= 1'b0;
        win_q     <= 1'b0;
      end
    end
  end

  assign fcw_ready = !pending_q;
  assign vco_out   = vco_q;
  assign ref_out   = ref_q;
  assign win_edge  = win_q;
  assign fcw_cur   = fcw_cur_q;

endmodule

// File: tb/tb_fdc_stim_nco.sv
// Bench for fdc_stim_nco: a phase/time-based reference model is compared every cycle,
// plus directed period and handshake checks.
module tb_fdc_stim_nco;

  localparam int ACC_W   = 16;
  localparam int FCW_W   = 8;
  localparam int REF_DIV = 256;
  localparam int PHASE_M = 1 << ACC_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             run = 1'b0;
  logic [FCW_W-1:0] fcw_in = '0;
  logic             fcw_valid = 1'b0;
  logic             sweep_en = 1'b0;
  logic             fcw_ready;
  logic             vco_out;
  logic             ref_out;
  logic             win_edge;
  logic [FCW_W-1:0] fcw_cur;

  fdc_stim_nco #(.ACC_W(ACC_W), .FCW_W(FCW_W), .REF_DIV(REF_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .fcw_in    (fcw_in),
    .fcw_valid (fcw_valid),
    .fcw_ready (fcw_ready),
    .sweep_en  (sweep_en),
    .vco_out   (vco_out),
    .ref_out   (ref_out),
    .win_edge  (win_edge),
    .fcw_cur   (fcw_cur)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: time since run start drives the reference, phase is an integer sum.
  int  m_n;
  int  m_phase;
  int  m_fcw;
  int  m_pval;
  bit  m_running, m_vco, m_win, m_pend;
  bit  s_active, s_win, s_take, s_commit;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0; m_phase = 0; m_fcw = 0; m_pval = 0;
      m_running = 0; m_vco = 0; m_win = 0; m_pend = 0;
    end else begin
      s_active = m_running && run;
      s_win    = s_active && (((m_n + 1) % (2 * REF_DIV)) == REF_DIV);
      s_take   = fcw_valid && !m_pend;
      s_commit = m_pend && (!m_running || s_win);
      if (s_active) begin
        m_vco   = (m_phase >= PHASE_M / 2);
        m_phase = (m_phase + m_fcw) % PHASE_M;
        m_n     = m_n + 1;
      end else begin
        m_vco = 0; m_phase = 0; m_n = 0;
      end
      m_win = s_win;
      if (s_commit) begin
        m_fcw  = m_pval;
        m_pend = 0;
      end
`ifdef FDC_NCO_SWEEP_EN
      else if (s_win && sweep_en) begin
        m_fcw = (m_fcw == (1 << FCW_W) - 1) ? 1 : m_fcw + 1;
      end
`endif
      if (s_take) begin
        m_pval = fcw_in;
        m_pend = 1;
      end
      m_running = run;
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("vco_out", vco_out, m_vco);
      check("ref_out", ref_out, ((m_n / REF_DIV) % 2));
      check("win_edge", win_edge, m_win);
      check("fcw_ready", fcw_ready, !m_pend);
      check("fcw_cur", fcw_cur, m_fcw);
    end
  end

  task automatic wait_win(output int at);
    at = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (win_edge) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check("win_edge_timeout", 0, 1);
  endtask

  task automatic wait_vco(input bit level, output int at);
    logic p;
    at = -1;
    p = vco_out;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (p != level && vco_out == level) begin
        at = cyc;
        break;
      end
      p = vco_out;
    end
    if (at < 0) check("vco_edge_timeout", 0, 1);
  endtask

  task automatic load(input int val);
    @(negedge clk);
    fcw_in = FCW_W'(val);
    fcw_valid = 1'b1;
    @(negedge clk);
    fcw_valid = 1'b0;
  endtask

  int t0, t1, t2, changes;
  logic v0;

  initial begin
    #22;
    check("rst_vco", vco_out, 0);
    check("rst_ref", ref_out, 0);
    check("rst_win", win_edge, 0);
    check("rst_ready", fcw_ready, 1);
    check("rst_fcw_cur", fcw_cur, 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle load commits on the next edge, then run.
    load(128);
    check("idle_pending_ready", fcw_ready, 0);
    @(negedge clk);
    check("idle_commit", fcw_cur, 128);
    run = 1'b1;
    wait_win(t0);
    wait_win(t1);
    check("win_period_512", t1 - t0, 512);
    wait_vco(1'b1, t0);
    wait_vco(1'b0, t1);
    wait_vco(1'b1, t2);
    check("vco128_high", t1 - t0, 256);
    check("vco128_period", t2 - t0, 512);

    // Mid-window load, second load while pending is dropped.
    wait_win(t0);
    repeat (100) @(negedge clk);
    load(64);
    fcw_in = 8'd99;
    fcw_valid = 1'b1;
    @(negedge clk);
    fcw_valid = 1'b0;
    check("pending_not_ready", fcw_ready, 0);
    wait_win(t1);
    check("commit_at_edge", fcw_cur, 64);
    check("commit_edge_time", t1 - t0, 512);
    wait_vco(1'b1, t0);
    wait_vco(1'b1, t1);
    wait_vco(1'b1, t2);
    check("vco64_period", t2 - t1, 1024);
    check("dropped_second", fcw_cur, 64);

    // Load coincident with a window edge: commit one full window later.
    wait_win(t0);
    repeat (511) @(negedge clk);
    fcw_in = 8'd200;
    fcw_valid = 1'b1;
    @(negedge clk);
    fcw_valid = 1'b0;
    check("coinc_win", win_edge, 1);
    check("coinc_no_commit", fcw_cur, 64);
    check("coinc_pending", fcw_ready, 0);
    t0 = cyc;
    wait_win(t1);
    check("coinc_later_edge", t1 - t0, 512);
    check("coinc_commit", fcw_cur, 200);

    // FCW=0: DC output.
    load(0);
    wait_win(t0);
    v0 = vco_out;
    changes = 0;
    repeat (1500) begin
      @(negedge clk);
      if (vco_out != v0) changes++;
    end
    check("fcw0_dc", changes, 0);

    // FCW=255: period close to 2^16/255.
    load(255);
    wait_win(t0);
    wait_vco(1'b1, t0);
    wait_vco(1'b1, t1);
    check("fcw255_period", (t1 - t0 >= 256 && t1 - t0 <= 258), 1);

`ifdef FDC_NCO_SWEEP_EN
    load(254);
    wait_win(t0);
    check("sweep_load", fcw_cur, 254);
    sweep_en = 1'b1;
    wait_win(t0);
    check("sweep_255", fcw_cur, 255);
    wait_win(t0);
    check("sweep_wrap1", fcw_cur, 1);
    wait_win(t0);
    check("sweep_2", fcw_cur, 2);
    sweep_en = 1'b0;
`endif

    // Asynchronous reset mid-run with an update pending.
    load(77);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_vco", vco_out, 0);
    check("arst_ref", ref_out, 0);
    check("arst_win", win_edge, 0);
    check("arst_ready", fcw_ready, 1);
    check("arst_fcw_cur", fcw_cur, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic.
    repeat (20000) begin
      @(negedge clk);
      if ($urandom_range(0, 1999) == 0) run = ~run;
      if ($urandom_range(0, 999) == 0) sweep_en = ~sweep_en;
      fcw_valid = ($urandom_range(0, 49) == 0);
      fcw_in = FCW_W'($urandom);
    end
    fcw_valid = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
